// File: rtl/neuron_pkg.sv
// Shared constants, state encoding and slot-offset helper for the sonar
// neuron datapath; imported by the assembler and by the neuron modules.
package neuron_pkg;

    localparam int N_FEATURES = 60;
    localparam int W_FIX      = 16;
    localparam int SAMPLE_W   = N_FEATURES * W_FIX;
    localparam int IDX_W      = $clog2(N_FEATURES);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic int featureOffset(input int i);
        return i * W_FIX;
    endfunction

endpackage

// File: rtl/uzorak_assembler.sv
// Serial-to-parallel assembler producing the 960-bit uzorak sample bus.
// Optional double buffering with UZORAK_ASSEMBLER_DOUBLE_BUFFER_EN.
module uzorak_assembler
    import neuron_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W_FIX-1:0]    in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] uzorak,
    output logic                frame_err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEATURES - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SAMPLE_W-1:0]   uzorak_q, uzorak_d;
    logic                  outValid_q, outValid_d;
    logic                  inReady_q, inReady_d;
    logic                  frameErr_q, frameErr_d;

    logic inXfer, outXfer, lastSlot, frameDone, frameBad;

    assign inXfer    = in_valid & inReady_q;
    assign outXfer   = outValid_q & out_ready;
    assign lastSlot  = (idx_q == LAST_IDX);
    assign frameDone = inXfer & lastSlot & in_last;
    // A frame is malformed when in_last and the final slot disagree.
    assign frameBad  = inXfer & (lastSlot ^ in_last);

`ifdef UZORAK_ASSEMBLER_DOUBLE_BUFFER_EN

    logic [SAMPLE_W-1:0] shadow_q, shadow_d;
    logic                shadowFull_q, shadowFull_d;

    // Words always land in the shadow; uzorak is loaded wholesale from it.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        uzorak_d     = uzorak_q;
        outValid_d   = outValid_q;
        inReady_d    = inReady_q;
        frameErr_d   = frameBad;
        shadow_d     = shadow_q;
        shadowFull_d = shadowFull_q;

        if (inXfer) begin
            for (int s = 0; s < N_FEATURES; s++) begin
                if (idx_q == IDX_W'(s)) begin
                    shadow_d[featureOffset(s) +: W_FIX] = in_data;
                end
            end
            idx_d = (frameDone || frameBad) ? '0 : idx_q + IDX_W'(1);
        end

        if (frameDone) begin
            if (state_q == FILL || outXfer) begin
                uzorak_d   = shadow_d;
                state_d    = HOLD;
                outValid_d = 1'b1;
                inReady_d  = 1'b1;
            end else begin
                shadowFull_d = 1'b1;
                inReady_d    = 1'b0;
            end
        end else if (state_q == HOLD && outXfer) begin
            if (shadowFull_q) begin
                uzorak_d     = shadow_q;
                shadowFull_d = 1'b0;
                inReady_d    = 1'b1;
            end else begin
                state_d    = FILL;
                outValid_d = 1'b0;
                inReady_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q     <= '0;
            shadowFull_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            shadowFull_q <= shadowFull_d;
        end
    end

`else

    // Single buffer: words are written straight into the presented vector.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        uzorak_d   = uzorak_q;
        outValid_d = outValid_q;
        inReady_d  = inReady_q;
        frameErr_d = frameBad;

        if (inXfer) begin
            for (int s = 0; s < N_FEATURES; s++) begin
                if (idx_q == IDX_W'(s)) begin
                    uzorak_d[featureOffset(s) +: W_FIX] = in_data;
                end
            end
            idx_d = (frameDone || frameBad) ? '0 : idx_q + IDX_W'(1);
        end

        if (frameDone) begin
            state_d    = HOLD;
            outValid_d = 1'b1;
            inReady_d  = 1'b0;
        end else if (state_q == HOLD && outXfer) begin
            state_d    = FILL;
            outValid_d = 1'b0;
            inReady_d  = 1'b1;
        end
    end

`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FILL;
            idx_q      <= '0;
            uzorak_q   <= '0;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            uzorak_q   <= uzorak_d;
            outValid_q <= outValid_d;
            inReady_q  <= inReady_d;
            frameErr_q <= frameErr_d;
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign uzorak    = uzorak_q;
    assign frame_err = frameErr_q;

endmodule

// File: tb/tb_uzorak_assembler.sv
// Directed self-checking bench for uzorak_assembler; double-buffer checks
// run when UZORAK_ASSEMBLER_DOUBLE_BUFFER_EN is defined.
module tb_uzorak_assembler;
    import neuron_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [W_FIX-1:0]    in_data = '0;
    logic                in_last = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [SAMPLE_W-1:0] uzorak;
    logic                frame_err;

    int checkCount = 0;
    int failCount  = 0;

    uzorak_assembler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .uzorak    (uzorak),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [SAMPLE_W-1:0] observed,
                               input logic [SAMPLE_W-1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SAMPLE_W-1:0] expVec(input logic [15:0] base);
        logic [SAMPLE_W-1:0] v;
        for (int i = 0; i < N_FEATURES; i++) v[i*W_FIX +: W_FIX] = base + 16'(i + 1);
        return v;
    endfunction

    // Present one word and wait (bounded) for it to be accepted.
    task automatic sendWord(input logic [15:0] d, input logic l);
        int waitCnt = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && waitCnt < 200) begin
            tick();
            waitCnt++;
        end
        if (!in_ready) checkOutput("inReadyWait", SAMPLE_W'(in_ready), SAMPLE_W'(1));
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] base, input int n, input logic lastOnFinal,
                                 input logic gap);
        for (int i = 0; i < n; i++) begin
            sendWord(base + 16'(i + 1), lastOnFinal && (i == n - 1));
            if (gap) tick();
        end
    endtask

    task automatic releaseSample();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_inReady"},  SAMPLE_W'(in_ready),  SAMPLE_W'(1));
        checkOutput({tag, "_outValid"}, SAMPLE_W'(out_valid), SAMPLE_W'(0));
        checkOutput({tag, "_frameErr"}, SAMPLE_W'(frame_err), SAMPLE_W'(0));
        checkOutput({tag, "_uzorak"},   uzorak,               '0);
    endtask

    task automatic fullFrame(input string tag, input logic [15:0] base, input logic gap);
        applyStimulus(base, N_FEATURES - 1, 1'b0, gap);
        checkOutput({tag, "_validBeforeLast"}, SAMPLE_W'(out_valid), SAMPLE_W'(0));
        sendWord(base + 16'(N_FEATURES), 1'b1);
        checkOutput({tag, "_validAfterLast"}, SAMPLE_W'(out_valid), SAMPLE_W'(1));
        checkOutput({tag, "_vector"}, uzorak, expVec(base));
    endtask

    initial begin
        logic [SAMPLE_W-1:0] held;

        tick();
        tick();
        checkResetState("reset");
        rst_n = 1'b1;

        fullFrame("seq", 16'h0000, 1'b0);
        checkOutput("seqLowSlot",  SAMPLE_W'(uzorak[15:0]),    SAMPLE_W'(16'h0001));
        checkOutput("seqHighSlot", SAMPLE_W'(uzorak[959:944]), SAMPLE_W'(16'h003C));
`ifndef UZORAK_ASSEMBLER_DOUBLE_BUFFER_EN
        checkOutput("seqInReadyHold", SAMPLE_W'(in_ready), SAMPLE_W'(0));
        held = uzorak;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom);
            in_last  = 1'($urandom_range(0, 1));
            tick();
            checkOutput("holdStable", uzorak, held);
            checkOutput("holdNoReady", SAMPLE_W'(in_ready), SAMPLE_W'(0));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
`else
        checkOutput("seqInReadyHoldDb", SAMPLE_W'(in_ready), SAMPLE_W'(1));
        for (int c = 0; c < 20; c++) tick();
        checkOutput("holdStableDb", uzorak, expVec(16'h0000));
`endif
        releaseSample();
        checkOutput("relOutValid", SAMPLE_W'(out_valid), SAMPLE_W'(0));
        checkOutput("relInReady",  SAMPLE_W'(in_ready),  SAMPLE_W'(1));

        applyStimulus(16'h0500, 10, 1'b1, 1'b0);
        checkOutput("earlyLastErr",   SAMPLE_W'(frame_err), SAMPLE_W'(1));
        checkOutput("earlyLastValid", SAMPLE_W'(out_valid), SAMPLE_W'(0));
        tick();
        checkOutput("earlyLastErrPulse", SAMPLE_W'(frame_err), SAMPLE_W'(0));
        fullFrame("afterEarly", 16'h8000, 1'b0);
        releaseSample();

        applyStimulus(16'h0600, N_FEATURES, 1'b0, 1'b0);
        checkOutput("missingLastErr",   SAMPLE_W'(frame_err), SAMPLE_W'(1));
        checkOutput("missingLastValid", SAMPLE_W'(out_valid), SAMPLE_W'(0));
        tick();
        checkOutput("missingLastErrPulse", SAMPLE_W'(frame_err), SAMPLE_W'(0));
        checkOutput("missingLastStillIdle", SAMPLE_W'(out_valid), SAMPLE_W'(0));
        fullFrame("afterMissing", 16'h1100, 1'b0);
        releaseSample();

        applyStimulus(16'h0700, 30, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkResetState("midReset");
        fullFrame("afterReset", 16'h4200, 1'b0);
        releaseSample();

        fullFrame("gapped", 16'h0000, 1'b1);
        releaseSample();

`ifdef UZORAK_ASSEMBLER_DOUBLE_BUFFER_EN
        fullFrame("dbA", 16'h2000, 1'b0);
        checkOutput("dbAInReady", SAMPLE_W'(in_ready), SAMPLE_W'(1));
        applyStimulus(16'h3000, N_FEATURES - 1, 1'b0, 1'b0);
        checkOutput("dbValidDuringB", SAMPLE_W'(out_valid), SAMPLE_W'(1));
        sendWord(16'h3000 + 16'(N_FEATURES), 1'b1);
        checkOutput("dbBInReadyLow", SAMPLE_W'(in_ready),  SAMPLE_W'(0));
        checkOutput("dbStillA",      uzorak,               expVec(16'h2000));
        checkOutput("dbValidAfterB", SAMPLE_W'(out_valid), SAMPLE_W'(1));
        releaseSample();
        checkOutput("dbSwapValid",   SAMPLE_W'(out_valid), SAMPLE_W'(1));
        checkOutput("dbSwapVector",  uzorak,               expVec(16'h3000));
        checkOutput("dbSwapInReady", SAMPLE_W'(in_ready),  SAMPLE_W'(1));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
